// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetcher with a PC, a BOOT/RUN/HALTED
// control FSM and a 2-entry {pc, instr} output FIFO.
//
// Output handshake: an entry is transferred on every rising clk edge where
// out_valid and out_ready are both 1; out_valid never depends on out_ready,
// and while out_valid=1 and out_ready=0 the head (out_pc/out_instr) is held.
module ifetch_unit #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] START_ADDR = ADDRWIDTH'(32'h01000000)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDRWIDTH-1:0] imem_address,
  output logic                 imem_read_write,
  input  logic [DATAWIDTH-1:0] imem_data_in,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH-1:0] out_pc,
  output logic [DATAWIDTH-1:0] out_instr,
  output logic [31:0]          fetch_count,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DATAWIDTH-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic [31:0]          fcnt_q, fcnt_d;

  logic pop;
  logic redir;
  logic push;
  logic pop_eff;

  // Handshake and control qualifiers; redirect is ignored only in BOOT.
  always_comb begin
    pop     = (cnt_q != 2'd0) && out_ready;
    redir   = redirect_valid && (state_q != ST_BOOT);
    push    = (state_q == ST_RUN) && !redirect_valid && !halt &&
              ((cnt_q != 2'd2) || pop);
    pop_eff = pop && !redir;
  end

  // Next control state: redirect wins over halt, HALTED only exits on redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid)  state_d = ST_RUN;
        else if (halt)       state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (redirect_valid)  state_d = ST_RUN;
      end
      default:   state_d = ST_BOOT;
    endcase
  end

  // Next PC and fetch counter; PC arithmetic wraps naturally at the width.
  always_comb begin
    pc_d = pc_q;
    if (redir)      pc_d = {redirect_pc[ADDRWIDTH-1:2], 2'b00};
    else if (push)  pc_d = pc_q + ADDRWIDTH'(4);
    fcnt_d = push ? (fcnt_q + 32'd1) : fcnt_q;
  end

  // FIFO update: slot 0 is always the head, slot 1 the tail when full.
  always_comb begin
    cnt_d  = cnt_q;
    pc0_d  = pc0_q;
    pc1_d  = pc1_q;
    ins0_d = ins0_q;
    ins1_d = ins1_q;
    if (redir) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = pc_q;
            ins1_d = imem_data_in;
          end else begin
            pc0_d  = pc_q;
            ins0_d = imem_data_in;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            pc0_d  = pc_q;
            ins0_d = imem_data_in;
          end else begin
            pc1_d  = pc_q;
            ins1_d = imem_data_in;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          pc0_d  = pc1_q;
          ins0_d = ins1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= START_ADDR;
      cnt_q   <= 2'd0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      ins0_q  <= '0;
      ins1_q  <= '0;
      fcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      ins0_q  <= ins0_d;
      ins1_q  <= ins1_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign imem_address    = pc_q;
  assign imem_read_write = 1'b0;
  assign out_valid       = (cnt_q != 2'd0);
  assign out_pc          = pc0_q;
  assign out_instr       = ins0_q;
  assign fetch_count     = fcnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 32, the instruction address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, the instruction word width.
REQ-003 SHALL have parameter START_ADDR, default 32'h01000000, the PC loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port imem_address, output, ADDRWIDTH bits, the word address presented to instruction memory.
REQ-007 SHALL have port imem_read_write, output, 1 bit, the memory write enable; tied to 0 (read only).
REQ-008 SHALL have port imem_data_in, input, DATAWIDTH bits, the combinational read data returned for imem_address in the same cycle.
REQ-009 SHALL have port redirect_valid, input, 1 bit, a request to restart fetch at redirect_pc.
REQ-010 SHALL have port redirect_pc, input, ADDRWIDTH bits, the new fetch address.
REQ-011 SHALL have port halt, input, 1 bit, a request to stop fetching.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning the buffer head holds an instruction.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the head this cycle.
REQ-014 SHALL have port out_pc, output, ADDRWIDTH bits, the address of the head instruction.
REQ-015 SHALL have port out_instr, output, DATAWIDTH bits, the head instruction word.
REQ-016 SHALL have port fetch_count, output, 32 bits, the number of words pushed into the buffer since reset.

Function
REQ-017 SHALL hold a PC register; imem_address equals PC combinationally, and imem_read_write is constant 0.
REQ-018 SHALL implement an FSM with three states:
- BOOT: entered on reset; no fetch; goes to RUN on the next clock edge.
- RUN: fetches.
- HALTED: no fetch.
REQ-019 SHALL define pop as out_valid AND out_ready; a popped entry is removed at the clock edge.
REQ-020 SHALL implement a 2-entry FIFO of {pc, instr}; the head drives out_pc and out_instr; out_valid = (count != 0).
REQ-021 SHALL, in RUN with no redirect_valid and no halt, define push as count < 2 OR pop; on push it writes {PC, imem_data_in}, advances PC by 4 and increments fetch_count.
REQ-022 SHALL allow push and pop in the same cycle; count is then unchanged and FIFO order is preserved.
REQ-023 SHALL make PC arithmetic modulo 2^ADDRWIDTH; the PC after 32'hFFFFFFFC is 32'h00000000.
REQ-024 SHALL, when redirect_valid=1 in any state except BOOT:
- load PC with {redirect_pc[ADDRWIDTH-1:2], 2'b00};
- empty the FIFO (count becomes 0);
- discard any pop that cycle;
- skip the push that cycle;
- enter RUN.
REQ-025 SHALL, when halt=1 in RUN and redirect_valid=0, skip the push, keep PC and FIFO contents (pops still allowed), and enter HALTED.
REQ-026 SHALL give redirect_valid priority over halt when both are asserted in the same cycle.
REQ-027 SHALL, in HALTED, leave the state only on redirect_valid; halt deassertion alone does not resume fetch.
REQ-028 SHALL ignore redirect_valid and halt while in BOOT.
REQ-029 SHALL make fetch_count wrap from 32'hFFFFFFFF to 0 and never reset it on redirect.
REQ-030 SHALL keep out_pc and out_instr stable while out_valid=1 and out_ready=0.

Reset
REQ-031 SHALL, while reset=1, asynchronously force: state = BOOT, PC = START_ADDR, FIFO count = 0, out_valid = 0, out_pc = 0, out_instr = 0, fetch_count = 0.
REQ-032 SHALL treat reset asserted mid-operation as above: in-flight FIFO contents are lost and no partial push occurs.
REQ-033 SHALL start fetching at START_ADDR on the second rising clock edge after reset deasserts.

Verification
REQ-034 Boot fetch: reset, memory holds 32'h00000093 at 32'h01000000 and 32'h00100113 at 32'h01000004, out_ready=1 -> out_pc=32'h01000000 with out_instr=32'h00000093, then the next cycle out_pc=32'h01000004 with out_instr=32'h00100113.
REQ-035 Backpressure: out_ready=0 for 5 cycles -> exactly 2 pushes; fetch_count=2; imem_address holds 32'h01000008; out_pc stays 32'h01000000.
REQ-036 Redirect with full FIFO: redirect_valid=1 with redirect_pc=32'h01000042 -> the next cycle has out_valid=0 and imem_address=32'h01000040; the first output afterwards has out_pc=32'h01000040.
REQ-037 Simultaneous events: halt=1 and redirect_valid=1 with redirect_pc=32'h01000010 in the same cycle -> state RUN and fetch from 32'h01000010; then halt=1 alone -> FIFO drains and imem_address stays constant.
REQ-038 Wrap-around: redirect_pc=32'hFFFFFFFC -> consecutive out_pc values 32'hFFFFFFFC then 32'h00000000.
REQ-039 Reset mid-stream: assert reset with the FIFO holding 2 entries -> out_valid=0, fetch_count=0 and imem_address=32'h01000000 immediately, without waiting for a clock edge.
